// File: rtl/down_cnt_reload_if.sv
// Control/status bundle for the loadable down-counter.
// The controller uses the master modport and the counter block uses the slave modport.
interface down_cnt_reload_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, en, auto_reload,
    input  counter, tc, busy
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output counter, tc, busy
  );
endinterface

// File: rtl/down_cnt_reload.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// It either stops at zero (one-shot) or reloads the stored start value (auto-reload). All outputs are registered.
module down_cnt_reload #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  down_cnt_reload_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      reload_reg  <= ZERO;
      bus.counter <= ZERO;
      bus.tc      <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      // tc is high for only one cycle. It is set again below only on a terminal decrement.
      bus.tc <= 1'b0;
      if (bus.load) begin
        bus.counter <= bus.load_val;
        reload_reg  <= bus.load_val;
        if (bus.load_val != ZERO) begin
          state    <= S_RUN;
          bus.busy <= 1'b1;
        end else begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: bus.busy <= 1'b0;
          S_RUN: begin
            if (!bus.en) begin
              state <= S_PAUSE;
            end else if (bus.counter > ONE) begin
              bus.counter <= bus.counter - ONE;
            end else if (bus.counter == ONE) begin
              bus.tc <= 1'b1;
              if (bus.auto_reload) begin
                bus.counter <= reload_reg;
              end else begin
                bus.counter <= ZERO;
                state       <= S_IDLE;
                bus.busy    <= 1'b0;
              end
            end else begin
              // RUN with a zero count is not reachable. Park the block rather than wrap.
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end
          // Resuming costs one edge: no decrement on the PAUSE->RUN transition
          S_PAUSE: if (bus.en) state <= S_RUN;
          default: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
